fsk_frame_demod: RTL

- Receive-side counterpart to the FSK modulator.
- Samples the single-bit square-wave FSK line on the oversampling clock and recovers bit values by counting carrier edges per bit window.
- Frames start/data/stop, and delivers 12-bit Hamming codewords to the Hamming decoder over a valid/ready handshake.
- Flags framing errors and overruns.

---
 rtl/fsk_pkg.sv | 26 ++
 rtl/fsk_edge_window.sv | 107 ++++++++++
 rtl/fsk_frame_demod.sv | 150 +++++++++++++++
 3 files changed

// File: rtl/fsk_pkg.sv
// Shared types and constants for the FSK frame receiver (fsk_edge_window + fsk_frame_demod).
// Optional build macro FSK_GLITCH_FILTER_EN is consumed by fsk_edge_window.
package fsk_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } fsk_state_e;

    localparam int CW_W_DEF   = 12;
    localparam int EDGES_ZERO = 2;
    localparam int EDGES_ONE  = 4;

    localparam logic START_BIT = 1'b0;
    localparam logic STOP_BIT  = 1'b1;

    localparam int              EDGE_CNT_W   = 3;
    localparam logic [EDGE_CNT_W-1:0] EDGE_CNT_MAX = 3'd7;

    function automatic logic maj3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage

// File: rtl/fsk_edge_window.sv
// Line synchronizer, rise detector and per-bit-window edge counter; emits one decision per window.
// Build macro FSK_GLITCH_FILTER_EN inserts a majority-of-3 filter ahead of the rise detector.
module fsk_edge_window
    import fsk_pkg::*;
#(
    parameter int SPB         = 16,
    parameter int EDGE_THRESH = 3
) (
    input  logic clk,
    input  logic reset,
    input  logic datain,
    input  logic run,
    output logic start_rise,
    output logic bit_done,
    output logic bit_val
);

    localparam int              WIN_W    = $clog2(SPB);
    localparam logic [WIN_W-1:0] WIN_LAST = WIN_W'(SPB - 1);

    logic sync1_q, sync1_d;
    logic sync2_q, sync2_d;
    logic prev_q,  prev_d;
    logic line_s;
    logic rise;

    logic [WIN_W-1:0]      win_cnt_q,  win_cnt_d;
    logic [EDGE_CNT_W-1:0] edge_cnt_q, edge_cnt_d;
    logic [EDGE_CNT_W:0]   edge_sum;

`ifdef FSK_GLITCH_FILTER_EN
    logic hist1_q, hist1_d;
    logic hist2_q, hist2_d;
    logic filt_q,  filt_d;

    always_comb begin
        hist1_d = sync2_q;
        hist2_d = hist1_q;
        filt_d  = maj3(sync2_q, hist1_q, hist2_q);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            hist1_q <= 1'b0;
            hist2_q <= 1'b0;
            filt_q  <= 1'b0;
        end else begin
            hist1_q <= hist1_d;
            hist2_q <= hist2_d;
            filt_q  <= filt_d;
        end
    end

    assign line_s = filt_q;
`else
    assign line_s = sync2_q;
`endif

    always_comb begin
        sync1_d = datain;
        sync2_d = sync1_q;
        prev_d  = line_s;
    end

    assign rise     = line_s & ~prev_q;
    assign edge_sum = {1'b0, edge_cnt_q} + {{EDGE_CNT_W{1'b0}}, rise};

    // A rise while idle is index 0 of the start window and already counts as edge 1.
    always_comb begin
        win_cnt_d  = win_cnt_q;
        edge_cnt_d = edge_cnt_q;
        bit_done   = 1'b0;
        bit_val    = 1'b0;
        start_rise = rise & ~run;
        if (!run) begin
            win_cnt_d  = rise ? WIN_W'(1) : '0;
            edge_cnt_d = rise ? EDGE_CNT_W'(1) : '0;
        end else if (win_cnt_q == WIN_LAST) begin
            bit_done   = 1'b1;
            bit_val    = (edge_sum >= (EDGE_CNT_W+1)'(EDGE_THRESH));
            win_cnt_d  = '0;
            edge_cnt_d = '0;
        end else begin
            win_cnt_d = win_cnt_q + WIN_W'(1);
            if (rise && (edge_cnt_q != EDGE_CNT_MAX)) begin
                edge_cnt_d = edge_cnt_q + EDGE_CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync1_q    <= 1'b0;
            sync2_q    <= 1'b0;
            prev_q     <= 1'b0;
            win_cnt_q  <= '0;
            edge_cnt_q <= '0;
        end else begin
            sync1_q    <= sync1_d;
            sync2_q    <= sync2_d;
            prev_q     <= prev_d;
            win_cnt_q  <= win_cnt_d;
            edge_cnt_q <= edge_cnt_d;
        end
    end

endmodule

// File: rtl/fsk_frame_demod.sv
// FSK frame receiver: start/data/stop framing, codeword shift register and valid/ready output.
// Build macro FSK_GLITCH_FILTER_EN (see fsk_edge_window) adds 2 clocks of input latency.
//
//   state | meaning
//   IDLE  | line quiet, waiting for a start rise
//   START | sampling start window; tone 1 here is treated as noise
//   DATA  | shifting in CW_W bits, MSB first
//   STOP  | sampling stop window; tone 1 delivers, tone 0 flags frame_err
module fsk_frame_demod
    import fsk_pkg::*;
#(
    parameter int SPB         = 16,
    parameter int EDGE_THRESH = (EDGES_ZERO + EDGES_ONE + 1) / 2,
    parameter int CW_W        = CW_W_DEF
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            datain,
    output logic [CW_W-1:0] dataout,
    output logic            out_valid,
    input  logic            out_ready,
    output logic            frame_err,
    output logic            overflow,
    output logic            busy
);

    localparam int IDX_W = $clog2(CW_W);

    fsk_state_e       state_q, state_d;
    logic [IDX_W-1:0] bit_idx_q, bit_idx_d;
    logic [CW_W-1:0]  shreg_q, shreg_d;
    logic             deliver_q, deliver_d;
    logic             frame_err_q, frame_err_d;
    logic [CW_W-1:0]  dout_q, dout_d;
    logic             valid_q, valid_d;
    logic             ovf_q, ovf_d;

    logic run;
    logic start_rise;
    logic bit_done;
    logic bit_val;

    assign run = (state_q != IDLE);

    fsk_edge_window #(
        .SPB         (SPB),
        .EDGE_THRESH (EDGE_THRESH)
    ) u_edge_window (
        .clk        (clk),
        .reset      (reset),
        .datain     (datain),
        .run        (run),
        .start_rise (start_rise),
        .bit_done   (bit_done),
        .bit_val    (bit_val)
    );

    always_comb begin
        state_d     = state_q;
        bit_idx_d   = bit_idx_q;
        shreg_d     = shreg_q;
        deliver_d   = 1'b0;
        frame_err_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (start_rise) begin
                    state_d = START;
                end
            end
            START: begin
                if (bit_done) begin
                    if (bit_val == START_BIT) begin
                        state_d   = DATA;
                        bit_idx_d = IDX_W'(CW_W - 1);
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            DATA: begin
                if (bit_done) begin
                    shreg_d = {shreg_q[CW_W-2:0], bit_val};
                    if (bit_idx_q == '0) begin
                        state_d = STOP;
                    end else begin
                        bit_idx_d = bit_idx_q - IDX_W'(1);
                    end
                end
            end
            STOP: begin
                if (bit_done) begin
                    state_d = IDLE;
                    if (bit_val == STOP_BIT) begin
                        deliver_d = 1'b1;
                    end else begin
                        frame_err_d = 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Delivery lands one cycle after the stop decision; a full, unaccepted slot drops the new word.
    always_comb begin
        dout_d  = dout_q;
        valid_d = valid_q;
        ovf_d   = ovf_q;
        if (valid_q && out_ready) begin
            valid_d = 1'b0;
        end
        if (deliver_q) begin
            if (!valid_q || out_ready) begin
                dout_d  = shreg_q;
                valid_d = 1'b1;
            end else begin
                ovf_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            bit_idx_q   <= '0;
            shreg_q     <= '0;
            deliver_q   <= 1'b0;
            frame_err_q <= 1'b0;
            dout_q      <= '0;
            valid_q     <= 1'b0;
            ovf_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            bit_idx_q   <= bit_idx_d;
            shreg_q     <= shreg_d;
            deliver_q   <= deliver_d;
            frame_err_q <= frame_err_d;
            dout_q      <= dout_d;
            valid_q     <= valid_d;
            ovf_q       <= ovf_d;
        end
    end

    assign dataout   = dout_q;
    assign out_valid = valid_q;
    assign frame_err = frame_err_q;
    assign overflow  = ovf_q;
    assign busy      = run;

endmodule
